// File: rtl/tc_pkg.sv
// tc_pkg -- shared definitions for the timer_counter block.
// FSM state encoding, register offsets, CTRL field positions and MODE
// encodings, plus a byte-lane merge helper for partial bus writes.
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'b00;
  localparam logic [1:0] REG_PRESET = 2'b01;
  localparam logic [1:0] REG_COUNT  = 2'b10;
  localparam logic [1:0] REG_RSVD   = 2'b11;

  // CTRL field positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE encodings; 10 and 11 fall back to one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Replace only the byte lanes whose enable bit is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// timer_counter -- bus-mapped down-counter with interrupt.
// Registers: CTRL (EN/MODE/IM), PRESET, COUNT (read-only), reserved slot.
// Auto-reload mode exists only when TC_AUTORELOAD_EN is defined; otherwise
// MODE is hardwired to one-shot and reads back as 00.
module timer_counter
  import tc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  tc_state_e   state;
  logic        en_q, im_q, irq_flag;
  logic [1:0]  mode_q;
  logic [31:0] preset_q, count_q;

  logic        en_d, im_d, flag_d;
  logic [31:0] preset_d, ctrl_rd;
  logic [1:0]  sel;
  logic        wr_ctrl, wr_preset, reload, hit_zero;
  logic        unused_addr;

  assign sel         = addr[3:2];
  assign unused_addr = ^addr[31:4];
  assign wr_ctrl     = (|byteen) && (sel == REG_CTRL);
  assign wr_preset   = (|byteen) && (sel == REG_PRESET);
  // Terminal count: the decrement that would reach (or pass) zero
  assign hit_zero    = (state == ST_CNT) && en_q && (count_q <= 32'd1);

`ifdef TC_AUTORELOAD_EN
  logic [1:0] mode_d;
  assign reload = (mode_q == MODE_RELOAD);

  // MODE register; only present when auto-reload is built in
  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_ONESHOT;
    else       mode_q <= mode_d;
  end
`else
  assign reload = 1'b0;
  assign mode_q = MODE_ONESHOT;
`endif

  // Next values of the bus-visible registers; bus writes override FSM side effects
  always_comb begin
    en_d = en_q;
    im_d = im_q;
`ifdef TC_AUTORELOAD_EN
    mode_d = mode_q;
`endif
    // one-shot expiry disarms the timer, unless the bus rewrites CTRL this cycle
    if (state == ST_INT && !reload) en_d = 1'b0;
    if (wr_ctrl && byteen[0]) begin
      en_d = din[CTRL_EN];
      im_d = din[CTRL_IM];
`ifdef TC_AUTORELOAD_EN
      mode_d = din[CTRL_MODE_HI:CTRL_MODE_LO];
`endif
    end
    preset_d = wr_preset ? byte_merge(preset_q, din, byteen) : preset_q;
    // any CTRL/PRESET write acknowledges; auto-reload drops it on leaving INT;
    // a fresh expiry in the same cycle still sets it
    flag_d = irq_flag;
    if (wr_ctrl || wr_preset || (state == ST_INT && reload)) flag_d = 1'b0;
    if (hit_zero) flag_d = 1'b1;
  end

  // FSM, counter and register file; irq is registered from next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      count_q  <= '0;
      en_q     <= 1'b0;
      im_q     <= 1'b0;
      preset_q <= '0;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      en_q     <= en_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      irq_flag <= flag_d;
      irq      <= flag_d & im_d;
      case (state)
        ST_IDLE: if (en_q) state <= ST_LOAD;
        ST_LOAD: begin
          count_q <= preset_q;
          state   <= ST_CNT;
        end
        ST_CNT: begin
          if (!en_q) state <= ST_IDLE;
          else if (hit_zero) begin
            count_q <= '0;
            state   <= ST_INT;
          end else count_q <= count_q - 32'd1;
        end
        ST_INT:  state <= reload ? ST_LOAD : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Combinational read mux
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN] = en_q;
    ctrl_rd[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
    ctrl_rd[CTRL_IM] = im_q;
    dout = '0;
    case (sel)
      REG_CTRL:   dout = ctrl_rd;
      REG_PRESET: dout = preset_q;
      REG_COUNT:  dout = count_q;
      REG_RSVD:   dout = '0;
      default:    dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter -- directed bench for timer_counter with a cycle model
// checked every cycle plus hand-computed literal expectations.
// Model follows TC_AUTORELOAD_EN the same way the design does.
module tb_timer_counter;
  import tc_pkg::*;

`ifdef TC_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam logic [1:0] P_IDLE = 2'd0, P_LOAD = 2'd1, P_RUN = 2'd2, P_EXP = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic [31:2] addr;
  logic [3:0]  byteen;
  logic [31:0] din, dout;
  logic        irq;
  bit          go = 1'b0;
  int          checks = 0, errors = 0;

  // upper address bits are junk on purpose: only [3:2] may decode
  assign addr = {28'hABCDEF1, sel};

  timer_counter dut (.clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
                     .din(din), .dout(dout), .irq(irq));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  phase;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    logic        irq;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t mstep(input mdl_t s, input logic rst, input logic [1:0] r,
                                 input logic [3:0] be, input logic [31:0] d);
    mdl_t n;
    logic wr;
    n  = s;
    wr = |be;
    if (rst) n = '0;
    else begin
      if (wr && (r == 2'd0 || r == 2'd1)) n.flag = 1'b0;
      case (s.phase)
        P_IDLE: if (s.en) n.phase = P_LOAD;
        P_LOAD: begin n.count = s.preset; n.phase = P_RUN; end
        P_RUN: begin
          if (!s.en) n.phase = P_IDLE;
          else if (s.count > 1) n.count = s.count - 1;
          else begin n.count = 0; n.phase = P_EXP; n.flag = 1'b1; end
        end
        default: begin
          if (AR && s.mode == 2'b01) begin n.phase = P_LOAD; n.flag = 1'b0; end
          else begin n.en = 1'b0; n.phase = P_IDLE; end
        end
      endcase
      if (wr && r == 2'd0 && be[0]) begin
        n.en = d[0];
        n.im = d[3];
        if (AR) n.mode = d[2:1];
      end
      if (wr && r == 2'd1)
        for (int i = 0; i < 4; i++) if (be[i]) n.preset[8*i +: 8] = d[8*i +: 8];
    end
    n.irq = n.flag & n.im;
    return n;
  endfunction

  function automatic logic [31:0] mread(input mdl_t s, input logic [1:0] r);
    logic [31:0] v;
    case (r)
      2'd0:    v = {28'd0, s.im, s.mode, s.en};
      2'd1:    v = s.preset;
      2'd2:    v = s.count;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // model advances on every active edge with the inputs the DUT sees
  initial forever begin
    @(posedge clk);
    m = mstep(m, reset, sel, byteen, din);
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (go) begin
      checks++;
      if (irq !== m.irq) begin
        errors++;
        $display("FAIL model irq t=%0t got %0b exp %0b", $time, irq, m.irq);
      end
      checks++;
      if (dout !== mread(m, sel)) begin
        errors++;
        $display("FAIL model dout sel=%0d t=%0t got %h exp %h", sel, $time, dout, mread(m, sel));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [3:0] be, input logic [31:0] d);
    sel = r; byteen = be; din = d;
    cyc();
    sel = REG_COUNT; byteen = 4'h0; din = 32'd0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] v;
    sel = r;
    #1;
    v = dout;
    sel = REG_COUNT;
    chk(nm, v, exp);
  endtask

  int ca[6] = '{0, 3, 2, 1, 0, 0};
  int ia[6] = '{0, 0, 0, 0, 1, 1};
  int hits;

  initial begin
    reset = 1'b1; sel = REG_COUNT; byteen = 4'h0; din = 32'd0;
    cyc();
    go = 1'b1;
    cyc();
    reset = 1'b0;
    chk("reset irq", {31'd0, irq}, 32'd0);
    chk_reg("reset ctrl", REG_CTRL, 32'd0);
    chk_reg("reset preset", REG_PRESET, 32'd0);
    chk_reg("reset count", REG_COUNT, 32'd0);

    // one-shot, PRESET=3: irq rises at edge 5 and holds
    wr(REG_PRESET, 4'hF, 32'd3);
    wr(REG_CTRL, 4'hF, 32'h9);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk_reg($sformatf("oneshot count e%0d", k + 1), REG_COUNT, ca[k]);
      chk($sformatf("oneshot irq e%0d", k + 1), {31'd0, irq}, ia[k]);
    end
    chk_reg("oneshot en cleared", REG_CTRL, 32'h8);
    repeat (3) cyc();
    chk("oneshot irq held", {31'd0, irq}, 32'd1);
    wr(REG_CTRL, 4'hF, 32'h8);
    chk("oneshot irq ack", {31'd0, irq}, 32'd0);

    // PRESET=0 behaves as 1: irq at edge 3
    wr(REG_PRESET, 4'hF, 32'd0);
    wr(REG_CTRL, 4'hF, 32'h9);
    cyc(); chk("p0 irq e1", {31'd0, irq}, 32'd0);
    cyc(); chk("p0 irq e2", {31'd0, irq}, 32'd0);
    cyc(); chk("p0 irq e3", {31'd0, irq}, 32'd1);
    wr(REG_CTRL, 4'hF, 32'h8);
    cyc();

    // CTRL write in the expiry cycle beats the automatic EN clear
    wr(REG_PRESET, 4'hF, 32'd1);
    wr(REG_CTRL, 4'hF, 32'h9);
    repeat (3) cyc();
    chk("race irq e3", {31'd0, irq}, 32'd1);
    wr(REG_CTRL, 4'hF, 32'h9);
    chk_reg("race ctrl kept", REG_CTRL, 32'h9);
    chk("race irq ack", {31'd0, irq}, 32'd0);
    repeat (3) cyc();
    chk("race rearmed irq", {31'd0, irq}, 32'd1);
    wr(REG_CTRL, 4'hF, 32'h8);
    chk_reg("race stop ctrl", REG_CTRL, 32'h8);

    // MODE=01: pulse train with macro, single held irq without
    wr(REG_PRESET, 4'hF, 32'd2);
    wr(REG_CTRL, 4'hF, 32'hB);
    chk_reg("reload ctrl rd", REG_CTRL, AR ? 32'hB : 32'h9);
    hits = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      hits += int'(irq);
    end
    chk("reload irq cycles", hits, AR ? 32'd4 : 32'd13);
    wr(REG_CTRL, 4'hF, 32'h0);
    repeat (3) cyc();
    chk("reload stopped irq", {31'd0, irq}, 32'd0);

    // IM=0: flag sets silently, CTRL=0x8 acknowledges it
    wr(REG_PRESET, 4'hF, 32'd10);
    wr(REG_CTRL, 4'hF, 32'h1);
    repeat (14) cyc();
    chk("masked irq", {31'd0, irq}, 32'd0);
    chk_reg("masked en cleared", REG_CTRL, 32'h0);
    wr(REG_CTRL, 4'hF, 32'h8);
    chk("masked ack irq", {31'd0, irq}, 32'd0);
    chk_reg("masked ack ctrl", REG_CTRL, 32'h8);

    // stop mid-count; PRESET change waits for the next LOAD
    wr(REG_PRESET, 4'hF, 32'd8);
    wr(REG_CTRL, 4'hF, 32'h9);
    repeat (2) cyc();
    wr(REG_PRESET, 4'hF, 32'd20);
    cyc();
    chk_reg("midcnt count e4", REG_COUNT, 32'd6);
    wr(REG_CTRL, 4'hF, 32'h0);
    chk_reg("stop count e5", REG_COUNT, 32'd5);
    repeat (2) cyc();
    chk_reg("stop count held", REG_COUNT, 32'd5);
    wr(REG_COUNT, 4'hF, 32'hFFFFFFFF);
    chk_reg("count is read-only", REG_COUNT, 32'd5);
    wr(REG_RSVD, 4'hF, 32'hFFFFFFFF);
    chk_reg("reserved reads 0", REG_RSVD, 32'd0);

    // restart with the new PRESET, then reset mid-count against a write
    wr(REG_CTRL, 4'hF, 32'h9);
    repeat (4) cyc();
    chk_reg("restart count e4", REG_COUNT, 32'd18);
    reset = 1'b1; sel = REG_PRESET; byteen = 4'hF; din = 32'h55;
    cyc();
    reset = 1'b0; sel = REG_COUNT; byteen = 4'h0; din = 32'd0;
    chk("midreset irq", {31'd0, irq}, 32'd0);
    chk_reg("midreset ctrl", REG_CTRL, 32'd0);
    chk_reg("midreset preset", REG_PRESET, 32'd0);
    chk_reg("midreset count", REG_COUNT, 32'd0);

    // byte-lane writes to PRESET
    wr(REG_PRESET, 4'hF, 32'h11223344);
    wr(REG_PRESET, 4'b0010, 32'h0000AA00);
    chk_reg("lane1 preset", REG_PRESET, 32'h1122AA44);
    wr(REG_PRESET, 4'b1000, 32'hEE000000);
    chk_reg("lane3 preset", REG_PRESET, 32'hEE22AA44);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port addr, input, 30 bits [31:2]: word address of the bus access; bits [3:2] select the register.
REQ-004 SHALL have port byteen, input, 4 bits: byte write enables; a write occurs when any byteen bit is 1.
REQ-005 SHALL have port din, input, 32 bits: write data.
REQ-006 SHALL have port dout, output, 32 bits: read data, combinational from addr.
REQ-007 SHALL have port irq, output, 1 bit: interrupt request to the CPU interrupt input.

Function
REQ-008 SHALL use this register map: addr[3:2]=00 CTRL, 01 PRESET, 10 COUNT (read-only), 11 reserved (reads 0, writes ignored).
REQ-009 SHALL define CTRL as [0] EN, [2:1] MODE, [3] IM (interrupt mask); CTRL[31:4] SHALL read 0.
REQ-010 SHALL apply writes to CTRL and PRESET per byte lane; only lanes whose byteen bit is 1 are updated.
REQ-011 SHALL define MODE 00 as one-shot and MODE 01 as auto-reload; MODE 10 and 11 SHALL behave as 00.
REQ-012 SHALL implement the FSM states IDLE, LOAD, CNT and INT.
REQ-013 IDLE: if EN=1, next state SHALL be LOAD; otherwise stay in IDLE with COUNT held.
REQ-014 LOAD: COUNT SHALL load PRESET and the next state SHALL be CNT.
REQ-015 CNT: if EN=0, next state SHALL be IDLE with COUNT held.
REQ-016 CNT with EN=1: if COUNT>1, COUNT SHALL decrement; otherwise COUNT SHALL become 0, the next state SHALL be INT, and irq_flag SHALL set.
REQ-017 INT, one-shot mode: EN SHALL clear, the next state SHALL be IDLE, and irq_flag SHALL stay set until any CTRL or PRESET write.
REQ-018 INT, auto-reload mode: the next state SHALL be LOAD and irq_flag SHALL clear on leaving INT, giving a one-cycle pulse.
REQ-019 irq SHALL equal irq_flag AND IM, driven registered from flops.
REQ-020 A bus write to CTRL in the same cycle as the FSM clearing EN SHALL win.
REQ-021 A PRESET write during CNT SHALL take effect only at the next LOAD.
REQ-022 COUNT SHALL be 32-bit unsigned and never wrap below 0; PRESET=0 SHALL behave as PRESET=1.
REQ-023 Timing: after the edge that writes EN=1 with PRESET=N (N>=1), irq SHALL rise at edge N+2; the auto-reload period SHALL be N+2 cycles.

Reset
REQ-024 Reset SHALL set CTRL, PRESET, COUNT and irq_flag to 0 and the state to IDLE; irq SHALL be 0 in the cycle after reset.
REQ-025 Reset SHALL take priority over any simultaneous bus write, including one mid-count.

Configuration
REQ-026 With macro TC_AUTORELOAD_EN defined, MODE 01 SHALL operate as auto-reload.
REQ-027 Without TC_AUTORELOAD_EN, CTRL[2:1] SHALL be hardwired to 00 (writes ignored, reads 0) and only one-shot mode SHALL exist.

Structure
REQ-028 Package tc_pkg SHALL hold the FSM state enum, the register offsets, the CTRL bit positions and the MODE encodings.
REQ-029 The block SHALL be a single module; no sub-module is required.

Verification
REQ-030 PRESET=3, then CTRL=0x9 (EN, IM, one-shot) -> COUNT 3,2,1,0; irq=1 at edge 5 after the write, held; EN reads 0; irq clears on the next CTRL write.
REQ-031 PRESET=2, CTRL=0xB (auto-reload, IM), TC_AUTORELOAD_EN defined -> one-cycle irq pulse every 4 cycles; COUNT cycles 2,1,0.
REQ-032 Same stimulus without TC_AUTORELOAD_EN -> CTRL reads 0x9, a single held irq, then the counter stays IDLE.
REQ-033 PRESET=10, CTRL=0x1 (IM=0) -> irq stays 0; irq_flag sets; a later CTRL=0x8 write clears the flag, so irq stays 0.
REQ-034 During counting with COUNT=5, write CTRL=0 -> next edge IDLE, COUNT holds 5; reset asserted mid-count -> all registers 0, irq 0.
REQ-035 PRESET=0x11223344, write byteen=0010 with din=0x0000AA00 -> PRESET reads 0x1122AA44; a write to addr[3:2]=10 leaves COUNT unchanged.
